// File: rtl/if_id_skid_reg_if.sv
// Fetch->decode handshake bundle. Signal names follow the pipeline-stage
// suffixes (F = fetch side, D = decode side) so waveforms line up with the core.
interface if_id_skid_reg_if #(
    parameter int IW    = 32,
    parameter int AW    = 32,
    parameter int CNT_W = 16
);
    logic             FlushD;
    logic             ValidF;
    logic             ReadyF;
    logic [IW-1:0]    InstrF;
    logic [AW-1:0]    PCPlus4F;
    logic             ValidD;
    logic             ReadyD;
    logic [IW-1:0]    InstrD;
    logic [AW-1:0]    PCPlus4D;
    logic [CNT_W-1:0] SquashCnt;

    modport master (
        output FlushD, ValidF, InstrF, PCPlus4F, ReadyD,
        input  ReadyF, ValidD, InstrD, PCPlus4D, SquashCnt
    );

    modport slave (
        input  FlushD, ValidF, InstrF, PCPlus4F, ReadyD,
        output ReadyF, ValidD, InstrD, PCPlus4D, SquashCnt
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// Fetch->decode pipeline register with a 2-entry skid buffer (OUT + SKID),
// registered ready towards fetch, flush with a saturating squash counter.
module if_id_skid_reg #(
    parameter int             IW        = 32,
    parameter int             AW        = 32,
    parameter logic [IW-1:0]  NOP_INSTR = '0,
    parameter int             CNT_W     = 16
) (
    input logic                 CLK,
    input logic                 rst_n,
    if_id_skid_reg_if.slave     bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             out_valid, out_valid_n;
    logic [IW-1:0]    out_instr, out_instr_n;
    logic [AW-1:0]    out_pc, out_pc_n;
    logic             skid_valid, skid_valid_n;
    logic [IW-1:0]    skid_instr, skid_instr_n;
    logic [AW-1:0]    skid_pc, skid_pc_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             acc, pop;
    logic [1:0]       drops;
    logic [CNT_W+1:0] cnt_sum;

    // Ready is a pure function of state: no combinational path from ReadyD.
    assign acc = bus.ValidF & ~skid_valid;
    assign pop = out_valid & bus.ReadyD;

    assign drops   = {1'b0, out_valid & ~pop} + {1'b0, skid_valid} + {1'b0, acc};
    assign cnt_sum = {2'b00, cnt} + {{CNT_W{1'b0}}, drops};

    always_comb begin
        out_valid_n  = out_valid;
        out_instr_n  = out_instr;
        out_pc_n     = out_pc;
        skid_valid_n = skid_valid;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        cnt_n        = cnt;

        if (bus.FlushD) begin
            out_valid_n  = 1'b0;
            out_instr_n  = NOP_INSTR;
            out_pc_n     = bus.PCPlus4F;
            skid_valid_n = 1'b0;
            cnt_n        = (cnt_sum > {2'b00, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        end else if (skid_valid) begin
            if (pop) begin
                out_instr_n  = skid_instr;
                out_pc_n     = skid_pc;
                skid_valid_n = 1'b0;
            end
        end else if (!out_valid || pop) begin
            if (acc) begin
                out_valid_n = 1'b1;
                out_instr_n = bus.InstrF;
                out_pc_n    = bus.PCPlus4F;
            end else if (pop) begin
                out_valid_n = 1'b0;
                out_instr_n = NOP_INSTR;
            end
        end else if (acc) begin
            // OUT is stalled: park the beat behind it so order is kept.
            skid_valid_n = 1'b1;
            skid_instr_n = bus.InstrF;
            skid_pc_n    = bus.PCPlus4F;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_instr  <= NOP_INSTR;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            cnt        <= '0;
        end else begin
            out_valid  <= out_valid_n;
            out_instr  <= out_instr_n;
            out_pc     <= out_pc_n;
            skid_valid <= skid_valid_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            cnt        <= cnt_n;
        end
    end

    assign bus.ReadyF    = ~skid_valid;
    assign bus.ValidD    = out_valid;
    assign bus.InstrD    = out_instr;
    assign bus.PCPlus4D  = out_pc;
    assign bus.SquashCnt = cnt;
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: three instances (default, 2-bit counter,
// narrow 16/12 datapath) sharing one clock and reset.
module tb_if_id_skid_reg;
    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    if_id_skid_reg_if #(.IW(32), .AW(32), .CNT_W(16)) b0 ();
    if_id_skid_reg_if #(.IW(32), .AW(32), .CNT_W(2))  b1 ();
    if_id_skid_reg_if #(.IW(16), .AW(12), .CNT_W(16)) b2 ();

    if_id_skid_reg #(.IW(32), .AW(32), .NOP_INSTR(32'd0), .CNT_W(16)) dut0 (.CLK(CLK), .rst_n(rst_n), .bus(b0));
    if_id_skid_reg #(.IW(32), .AW(32), .NOP_INSTR(32'd0), .CNT_W(2))  dut1 (.CLK(CLK), .rst_n(rst_n), .bus(b1));
    if_id_skid_reg #(.IW(16), .AW(12), .NOP_INSTR(16'd0), .CNT_W(16)) dut2 (.CLK(CLK), .rst_n(rst_n), .bus(b2));

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        b0.FlushD = 0; b0.ValidF = 0; b0.InstrF = '0; b0.PCPlus4F = '0; b0.ReadyD = 0;
        b1.FlushD = 0; b1.ValidF = 0; b1.InstrF = '0; b1.PCPlus4F = '0; b1.ReadyD = 0;
        b2.FlushD = 0; b2.ValidF = 0; b2.InstrF = '0; b2.PCPlus4F = '0; b2.ReadyD = 0;
    endtask

    task automatic do_reset();
        cyc();
        idle_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        checks++; if (b0.ValidD !== 1'b0) begin errors++; $display("FAIL reset_validd got %b exp 0", b0.ValidD); end
        checks++; if (b0.ReadyF !== 1'b1) begin errors++; $display("FAIL reset_readyf got %b exp 1", b0.ReadyF); end
        checks++; if (b0.InstrD !== 32'd0) begin errors++; $display("FAIL reset_instrd got %h exp 0", b0.InstrD); end
        checks++; if (b0.PCPlus4D !== 32'd0) begin errors++; $display("FAIL reset_pcd got %h exp 0", b0.PCPlus4D); end
        checks++; if (b0.SquashCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", b0.SquashCnt); end
        cyc();
        rst_n = 1;
    endtask

    task automatic test_streaming();
        do_reset();
        b0.ValidF = 1; b0.ReadyD = 1;
        for (int i = 0; i < 8; i++) begin
            b0.InstrF   = 32'(32'hA0 + i);
            b0.PCPlus4F = 32'(4 * (i + 1));
            cyc();
            checks++; if (b0.ValidD !== 1'b1 || b0.InstrD !== 32'(32'hA0 + i))
                begin errors++; $display("FAIL stream_instr[%0d] got v=%b %h exp v=1 %h", i, b0.ValidD, b0.InstrD, 32'hA0 + i); end
            checks++; if (b0.PCPlus4D !== 32'(4 * (i + 1)) || b0.ReadyF !== 1'b1)
                begin errors++; $display("FAIL stream_pc_rdy[%0d] got pc=%h rdy=%b exp pc=%h rdy=1", i, b0.PCPlus4D, b0.ReadyF, 4 * (i + 1)); end
        end
        b0.ValidF = 0;
        cyc();
        checks++; if (b0.ValidD !== 1'b0 || b0.InstrD !== 32'd0)
            begin errors++; $display("FAIL stream_drain got v=%b %h exp v=0 0", b0.ValidD, b0.InstrD); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        b0.ReadyD = 0; b0.ValidF = 1; b0.InstrF = 32'h11; b0.PCPlus4F = 32'h100;
        cyc();
        checks++; if (b0.ValidD !== 1'b1 || b0.InstrD !== 32'h11 || b0.ReadyF !== 1'b1)
            begin errors++; $display("FAIL bp_load got v=%b %h rdy=%b exp v=1 11 rdy=1", b0.ValidD, b0.InstrD, b0.ReadyF); end
        b0.InstrF = 32'h22; b0.PCPlus4F = 32'h104;
        cyc();
        checks++; if (b0.ReadyF !== 1'b0 || b0.InstrD !== 32'h11)
            begin errors++; $display("FAIL bp_skid got rdy=%b %h exp rdy=0 11", b0.ReadyF, b0.InstrD); end
        b0.InstrF = 32'h33; b0.PCPlus4F = 32'h108;
        cyc();
        cyc();
        checks++; if (b0.ReadyF !== 1'b0 || b0.ValidD !== 1'b1 || b0.InstrD !== 32'h11 || b0.PCPlus4D !== 32'h100)
            begin errors++; $display("FAIL bp_hold got rdy=%b v=%b %h pc=%h exp rdy=0 v=1 11 pc=100", b0.ReadyF, b0.ValidD, b0.InstrD, b0.PCPlus4D); end
        b0.ReadyD = 1;
        cyc();
        checks++; if (b0.InstrD !== 32'h22 || b0.PCPlus4D !== 32'h104 || b0.ReadyF !== 1'b1)
            begin errors++; $display("FAIL bp_second got %h pc=%h rdy=%b exp 22 pc=104 rdy=1", b0.InstrD, b0.PCPlus4D, b0.ReadyF); end
        cyc();
        checks++; if (b0.ValidD !== 1'b1 || b0.InstrD !== 32'h33 || b0.PCPlus4D !== 32'h108)
            begin errors++; $display("FAIL bp_third got v=%b %h pc=%h exp v=1 33 pc=108", b0.ValidD, b0.InstrD, b0.PCPlus4D); end
        b0.ValidF = 0;
        cyc();
        checks++; if (b0.ValidD !== 1'b0)
            begin errors++; $display("FAIL bp_empty got v=%b exp 0", b0.ValidD); end
    endtask

    task automatic test_flush_full();
        do_reset();
        b0.ReadyD = 0; b0.ValidF = 1; b0.InstrF = 32'h11; b0.PCPlus4F = 32'h100;
        cyc();
        b0.InstrF = 32'h22; b0.PCPlus4F = 32'h104;
        cyc();
        // Both entries full: ReadyF is low, so the offered beat cannot be accepted.
        b0.FlushD = 1; b0.InstrF = 32'h33; b0.PCPlus4F = 32'h200;
        checks++; if (b0.ReadyF !== 1'b0)
            begin errors++; $display("FAIL flush_pre_rdy got %b exp 0", b0.ReadyF); end
        cyc();
        b0.FlushD = 0; b0.ValidF = 0;
        checks++; if (b0.ValidD !== 1'b0 || b0.InstrD !== 32'd0 || b0.PCPlus4D !== 32'h200 || b0.ReadyF !== 1'b1)
            begin errors++; $display("FAIL flush_full_out got v=%b %h pc=%h rdy=%b exp v=0 0 pc=200 rdy=1", b0.ValidD, b0.InstrD, b0.PCPlus4D, b0.ReadyF); end
        checks++; if (b0.SquashCnt !== 16'd2)
            begin errors++; $display("FAIL flush_full_cnt got %0d exp 2", b0.SquashCnt); end
        b0.ValidF = 1; b0.InstrF = 32'h55; b0.PCPlus4F = 32'h204;
        cyc();
        // OUT stalled + accepted beat in the flush cycle: two drops.
        b0.FlushD = 1; b0.InstrF = 32'h66; b0.PCPlus4F = 32'h208;
        cyc();
        b0.FlushD = 0; b0.ValidF = 0;
        checks++; if (b0.SquashCnt !== 16'd4 || b0.PCPlus4D !== 32'h208)
            begin errors++; $display("FAIL flush_acc_cnt got %0d pc=%h exp 4 pc=208", b0.SquashCnt, b0.PCPlus4D); end
        cyc();
        checks++; if (b0.ValidD !== 1'b0 || b0.InstrD !== 32'd0)
            begin errors++; $display("FAIL flush_acc_dropped got v=%b %h exp v=0 0", b0.ValidD, b0.InstrD); end
    endtask

    task automatic test_flush_pop();
        do_reset();
        b0.ReadyD = 0; b0.ValidF = 1; b0.InstrF = 32'h44; b0.PCPlus4F = 32'h300;
        cyc();
        b0.ValidF = 0; b0.ReadyD = 1; b0.FlushD = 1; b0.PCPlus4F = 32'h304;
        checks++; if (b0.ValidD !== 1'b1 || b0.InstrD !== 32'h44)
            begin errors++; $display("FAIL flush_pop_seen got v=%b %h exp v=1 44", b0.ValidD, b0.InstrD); end
        cyc();
        b0.FlushD = 0; b0.ReadyD = 0;
        checks++; if (b0.SquashCnt !== 16'd0 || b0.ValidD !== 1'b0 || b0.PCPlus4D !== 32'h304)
            begin errors++; $display("FAIL flush_pop_cnt got %0d v=%b pc=%h exp 0 v=0 pc=304", b0.SquashCnt, b0.ValidD, b0.PCPlus4D); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            b1.ReadyD = 0; b1.ValidF = 1; b1.InstrF = 32'(32'h10 + k); b1.PCPlus4F = 32'h400;
            cyc();
            b1.InstrF = 32'(32'h20 + k);
            cyc();
            b1.FlushD = 1;
            cyc();
            b1.FlushD = 0; b1.ValidF = 0;
            exp_cnt = (k == 0) ? 2'd2 : 2'd3;
            checks++; if (b1.SquashCnt !== exp_cnt)
                begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, b1.SquashCnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_skid_full();
        do_reset();
        b0.ReadyD = 0; b0.ValidF = 1; b0.InstrF = 32'h77; b0.PCPlus4F = 32'h500;
        cyc();
        b0.FlushD = 1; b0.InstrF = 32'h78;
        cyc();
        b0.FlushD = 0; b0.InstrF = 32'h79;
        cyc();
        b0.InstrF = 32'h7A;
        cyc();
        checks++; if (b0.ReadyF !== 1'b0 || b0.SquashCnt !== 16'd2 || b0.InstrD !== 32'h79)
            begin errors++; $display("FAIL rst_pre got rdy=%b cnt=%0d %h exp rdy=0 cnt=2 79", b0.ReadyF, b0.SquashCnt, b0.InstrD); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (b0.ValidD !== 1'b0 || b0.ReadyF !== 1'b1 || b0.InstrD !== 32'd0 || b0.PCPlus4D !== 32'd0 || b0.SquashCnt !== 16'd0)
            begin errors++; $display("FAIL rst_async got v=%b rdy=%b %h pc=%h cnt=%0d exp all reset", b0.ValidD, b0.ReadyF, b0.InstrD, b0.PCPlus4D, b0.SquashCnt); end
        b0.ValidF = 0;
        #1;
        rst_n = 1;
        cyc();
        checks++; if (b0.ValidD !== 1'b0 || b0.ReadyF !== 1'b1)
            begin errors++; $display("FAIL rst_after got v=%b rdy=%b exp v=0 rdy=1", b0.ValidD, b0.ReadyF); end
    endtask

    task automatic test_streaming_narrow();
        do_reset();
        b2.ValidF = 1; b2.ReadyD = 1;
        for (int i = 0; i < 8; i++) begin
            b2.InstrF   = 16'(16'hA0 + i);
            b2.PCPlus4F = 12'(4 * (i + 1));
            cyc();
            checks++; if (b2.ValidD !== 1'b1 || b2.InstrD !== 16'(16'hA0 + i) || b2.PCPlus4D !== 12'(4 * (i + 1)) || b2.ReadyF !== 1'b1)
                begin errors++; $display("FAIL narrow_stream[%0d] got v=%b %h pc=%h rdy=%b exp v=1 %h pc=%h rdy=1", i, b2.ValidD, b2.InstrD, b2.PCPlus4D, b2.ReadyF, 16'hA0 + i, 4 * (i + 1)); end
        end
        b2.ValidF = 0;
        cyc();
        checks++; if (b2.ValidD !== 1'b0 || b2.InstrD !== 16'd0)
            begin errors++; $display("FAIL narrow_drain got v=%b %h exp v=0 0", b2.ValidD, b2.InstrD); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_flush_pop();
        test_saturation();
        test_reset_skid_full();
        test_streaming_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
